// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating a small serial NOR flash, oversampled by sys_clk.
// Implements WREN/WRDI/RDSR/RDID/READ/PP against an internal byte array.
module spi_flash_responder #(
   parameter int          DEPTH    = 256,
   parameter logic [23:0] JEDEC_ID = 24'hEF4017,
   parameter logic [7:0]  INIT_VAL = 8'hFF
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        spi_cs,
   input  logic        spi_clk,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        cmd_vld,
   output logic [7:0]  cmd_code,
   output logic        prog_vld,
   output logic [23:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic        erro_flag
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, STAT, ID, SKIP} state_t;

   state_t        state, state_nxt;
   logic [1:0]    cs_sync, clk_sync, mosi_sync;
   logic          clk_prev;
   logic          cs_s, rise, fall, byte_done;
   logic [2:0]    bit_cnt;
   logic [6:0]    rx_shift;
   logic [7:0]    rx_full, tx_shift, tx_byte, mem_wdata;
   logic [1:0]    addr_cnt, id_idx;
   logic [AW-1:0] addr;
   logic          wel, pp_wrote, load_pend, cmd_err, mem_we;
   logic [7:0]    mem [DEPTH];

   // cs resets to its idle (high) level so nothing is decoded until the master selects us
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cs_sync   <= 2'b11;
         clk_sync  <= 2'b00;
         mosi_sync <= 2'b00;
         clk_prev  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], spi_cs};
         clk_sync  <= {clk_sync[0], spi_clk};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         clk_prev  <= clk_sync[1];
      end
   end

   assign cs_s      = cs_sync[1];
   assign rise      = ~cs_s & clk_sync[1] & ~clk_prev;
   assign fall      = ~cs_s & ~clk_sync[1] & clk_prev;
   assign rx_full   = {rx_shift, mosi_sync[1]};
   assign byte_done = rise && (bit_cnt == 3'd7);
   assign mem_we    = byte_done && (state == WR);
   assign mem_wdata = mem[addr] & rx_full;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_s) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = CMD;
            CMD: begin
               if (byte_done) begin
                  case (rx_full)
                     8'h05:   state_nxt = STAT;
                     8'h9F:   state_nxt = ID;
                     8'h03:   state_nxt = ADDR;
                     8'h02:   state_nxt = wel ? ADDR : SKIP;
                     default: state_nxt = SKIP;
                  endcase
               end
            end
            ADDR: begin
               if (byte_done && addr_cnt == 2'd2)
                  state_nxt = (cmd_code == 8'h02) ? WR : RD;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // tx_byte is sampled one cycle after byte completion, once state/addr/id_idx have settled
   always_comb begin
      tx_byte = 8'h00;
      cmd_err = 1'b0;
      case (state)
         STAT: tx_byte = {6'b0, wel, 1'b0};
         ID: begin
            case (id_idx)
               2'd0:    tx_byte = JEDEC_ID[23:16];
               2'd1:    tx_byte = JEDEC_ID[15:8];
               2'd2:    tx_byte = JEDEC_ID[7:0];
               default: tx_byte = 8'h00;
            endcase
         end
         RD:      tx_byte = mem[addr];
         default: tx_byte = 8'h00;
      endcase
      if (byte_done && state == CMD) begin
         case (rx_full)
            8'h06, 8'h04, 8'h05, 8'h9F, 8'h03: cmd_err = 1'b0;
            8'h02:   cmd_err = ~wel;
            default: cmd_err = 1'b1;
         endcase
      end
   end

   // Deselect discards any partial byte and commits the end-of-PP WEL clear
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         spi_miso  <= 1'b0;
         cmd_vld   <= 1'b0;
         cmd_code  <= 8'h00;
         prog_vld  <= 1'b0;
         prog_addr <= 24'h0;
         prog_data <= 8'h00;
         erro_flag <= 1'b0;
         wel       <= 1'b0;
         pp_wrote  <= 1'b0;
         load_pend <= 1'b0;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         addr_cnt  <= '0;
         id_idx    <= '0;
         addr      <= '0;
      end else begin
         cmd_vld  <= 1'b0;
         prog_vld <= 1'b0;
         if (cs_s) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            spi_miso  <= 1'b0;
            load_pend <= 1'b0;
            addr_cnt  <= '0;
            id_idx    <= '0;
            if (pp_wrote) begin
               wel      <= 1'b0;
               pp_wrote <= 1'b0;
            end
         end else begin
            load_pend <= byte_done;
            if (rise) begin
               rx_shift <= rx_full[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end
            if (load_pend) begin
               tx_shift <= tx_byte;
            end else if (fall) begin
               spi_miso <= tx_shift[7];
               tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (byte_done) begin
               case (state)
                  CMD: begin
                     cmd_vld  <= 1'b1;
                     cmd_code <= rx_full;
                     if (rx_full == 8'h06)      wel <= 1'b1;
                     else if (rx_full == 8'h04) wel <= 1'b0;
                     if (cmd_err) erro_flag <= 1'b1;
                  end
                  ADDR: begin
                     addr     <= AW'({addr, rx_full});
                     addr_cnt <= addr_cnt + 2'd1;
                  end
                  RD: addr <= addr + AW'(1);
                  ID: begin
                     if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                  end
                  WR: begin
                     prog_vld  <= 1'b1;
                     prog_addr <= 24'(addr);
                     prog_data <= mem_wdata;
                     addr      <= addr + AW'(1);
                     pp_wrote  <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_mem
      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst)                          mem[g] <= INIT_VAL;
         else if (mem_we && addr == AW'(g))    mem[g] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: directed vector table, hand-written
// abort/reset sequences, and random transactions against a transaction-level flash model.
module tb_spi_flash_responder;
   localparam int DEPTH = 256;
   localparam int HALF  = 8;

   typedef struct {
      logic [63:0] tx;
      logic [63:0] rx;
      int          n;
      logic        err;
      int          nprog;
      logic [31:0] p0;
      logic [31:0] p1;
   } vec_t;

   logic        sys_clk, sys_rst, spi_cs, spi_clk, spi_mosi;
   logic        spi_miso, cmd_vld, prog_vld, erro_flag;
   logic [7:0]  cmd_code, prog_data;
   logic [23:0] prog_addr;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cmd_cnt = 0;
   int          cmd_seen, prog_start;
   logic [31:0] prog_log[$];
   logic [7:0]  act_rx[$];
   logic [7:0]  exp_rx[$];
   logic [31:0] exp_prog[$];
   logic [7:0]  exp_cmd;
   logic [7:0]  q[$];
   logic [7:0]  model_mem [DEPTH];
   logic        model_wel, model_err;
   vec_t        vecs[16];

   spi_flash_responder dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .spi_cs   (spi_cs),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .cmd_vld  (cmd_vld),
      .cmd_code (cmd_code),
      .prog_vld (prog_vld),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .erro_flag(erro_flag)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Strobe monitor: counts opcode pulses and logs every programmed byte
   always @(negedge sys_clk) begin
      if (cmd_vld) cmd_cnt++;
      if (prog_vld) prog_log.push_back({prog_addr, prog_data});
   end

   initial begin
      #10000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         repeat (HALF) @(negedge sys_clk);
         rx[7-i] = spi_miso;
         spi_clk = 1'b1;
         repeat (HALF) @(negedge sys_clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
      model_wel = 1'b0;
      model_err = 1'b0;
   endtask

   // Flash behaviour for one whole chip-select transaction
   task automatic model_txn(input logic [7:0] tx[$]);
      logic [23:0] a;
      logic [23:0] jid;
      int          n;
      int          loc;
      n   = tx.size();
      jid = 24'hEF4017;
      a   = 24'h0;
      exp_rx   = {};
      exp_prog = {};
      for (int i = 0; i < n; i++) exp_rx.push_back(8'h00);
      if (n == 0) return;
      exp_cmd = tx[0];
      for (int i = 1; i <= 3 && i < n; i++) a = {a[15:0], tx[i]};
      case (tx[0])
         8'h06: model_wel = 1'b1;
         8'h04: model_wel = 1'b0;
         8'h05: for (int i = 1; i < n; i++) exp_rx[i] = {6'b0, model_wel, 1'b0};
         8'h9F: for (int i = 1; i < n && i <= 3; i++) exp_rx[i] = jid[23-8*(i-1) -: 8];
         8'h03: for (int i = 4; i < n; i++) exp_rx[i] = model_mem[(int'(a) + i - 4) % DEPTH];
         8'h02: begin
            if (!model_wel) begin
               model_err = 1'b1;
            end else if (n > 4) begin
               for (int i = 4; i < n; i++) begin
                  loc = (int'(a) + i - 4) % DEPTH;
                  model_mem[loc] = model_mem[loc] & tx[i];
                  exp_prog.push_back({24'(loc), model_mem[loc]});
               end
               model_wel = 1'b0;
            end
         end
         default: model_err = 1'b1;
      endcase
   endtask

   task automatic applyStimulus(input logic [7:0] tx[$]);
      logic [7:0] r;
      int         c0;
      model_txn(tx);
      act_rx     = {};
      c0         = cmd_cnt;
      prog_start = prog_log.size();
      spi_cs = 1'b0;
      repeat (4) @(negedge sys_clk);
      foreach (tx[i]) begin
         xfer_bits(tx[i], 8, r);
         act_rx.push_back(r);
      end
      repeat (4) @(negedge sys_clk);
      spi_cs = 1'b1;
      repeat (8) @(negedge sys_clk);
      cmd_seen = cmd_cnt - c0;
   endtask

   task automatic compare_model(input string tag);
      int np;
      np = prog_log.size() - prog_start;
      foreach (exp_rx[i]) checkOutput($sformatf("%s miso[%0d]", tag, i), act_rx[i], exp_rx[i]);
      checkOutput({tag, " cmd_code"}, cmd_code, exp_cmd);
      checkOutput({tag, " cmd_vld count"}, cmd_seen, 1);
      checkOutput({tag, " erro_flag"}, erro_flag, model_err);
      checkOutput({tag, " prog count"}, np, exp_prog.size());
      for (int k = 0; k < np && k < exp_prog.size(); k++)
         checkOutput($sformatf("%s prog[%0d]", tag, k), prog_log[prog_start+k], exp_prog[k]);
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, " spi_miso"},  spi_miso,  0);
      checkOutput({tag, " cmd_vld"},   cmd_vld,   0);
      checkOutput({tag, " cmd_code"},  cmd_code,  0);
      checkOutput({tag, " prog_vld"},  prog_vld,  0);
      checkOutput({tag, " prog_addr"}, prog_addr, 0);
      checkOutput({tag, " prog_data"}, prog_data, 0);
      checkOutput({tag, " erro_flag"}, erro_flag, 0);
   endtask

   initial begin
      logic [7:0]  r;
      logic [15:0] hi;
      logic [7:0]  lo;
      int          sel;
      int          np;

      sys_rst  = 1'b1;
      spi_cs   = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_reset_values("por");
      sys_rst = 1'b0;
      model_reset();
      repeat (4) @(negedge sys_clk);

      // Directed transactions, applied in order from a fresh reset
      vecs[0]  = '{64'h9F00_0000_0000_0000, 64'h00EF_4017_0000_0000, 5, 1'b0, 0, 32'h0, 32'h0};
      vecs[1]  = '{64'h0500_0000_0000_0000, 64'h0000_0000_0000_0000, 2, 1'b0, 0, 32'h0, 32'h0};
      vecs[2]  = '{64'h0600_0000_0000_0000, 64'h0000_0000_0000_0000, 1, 1'b0, 0, 32'h0, 32'h0};
      vecs[3]  = '{64'h0500_0000_0000_0000, 64'h0002_0000_0000_0000, 2, 1'b0, 0, 32'h0, 32'h0};
      vecs[4]  = '{64'h0400_0000_0000_0000, 64'h0000_0000_0000_0000, 1, 1'b0, 0, 32'h0, 32'h0};
      vecs[5]  = '{64'h0500_0000_0000_0000, 64'h0000_0000_0000_0000, 2, 1'b0, 0, 32'h0, 32'h0};
      vecs[6]  = '{64'h0600_0000_0000_0000, 64'h0000_0000_0000_0000, 1, 1'b0, 0, 32'h0, 32'h0};
      vecs[7]  = '{64'h0200_0010_A53C_0000, 64'h0000_0000_0000_0000, 6, 1'b0, 2, 32'h0000_10A5, 32'h0000_113C};
      vecs[8]  = '{64'h0300_000F_0000_0000, 64'h0000_0000_FFA5_3C00, 7, 1'b0, 0, 32'h0, 32'h0};
      vecs[9]  = '{64'h0500_0000_0000_0000, 64'h0000_0000_0000_0000, 2, 1'b0, 0, 32'h0, 32'h0};
      vecs[10] = '{64'h0600_0000_0000_0000, 64'h0000_0000_0000_0000, 1, 1'b0, 0, 32'h0, 32'h0};
      vecs[11] = '{64'h0200_00FF_1122_0000, 64'h0000_0000_0000_0000, 6, 1'b0, 2, 32'h0000_FF11, 32'h0000_0022};
      vecs[12] = '{64'h0300_00FF_0000_0000, 64'h0000_0000_1122_0000, 6, 1'b0, 0, 32'h0, 32'h0};
      vecs[13] = '{64'h0200_0020_7700_0000, 64'h0000_0000_0000_0000, 5, 1'b1, 0, 32'h0, 32'h0};
      vecs[14] = '{64'h0300_0020_0000_0000, 64'h0000_0000_FF00_0000, 5, 1'b1, 0, 32'h0, 32'h0};
      vecs[15] = '{64'hAB00_0000_0000_0000, 64'h0000_0000_0000_0000, 2, 1'b1, 0, 32'h0, 32'h0};

      for (int k = 0; k < 16; k++) begin
         q = {};
         for (int i = 0; i < vecs[k].n; i++) q.push_back(vecs[k].tx[63-8*i -: 8]);
         applyStimulus(q);
         for (int i = 0; i < vecs[k].n; i++)
            checkOutput($sformatf("vec%0d miso[%0d]", k, i), act_rx[i], vecs[k].rx[63-8*i -: 8]);
         checkOutput($sformatf("vec%0d cmd_code", k), cmd_code, vecs[k].tx[63:56]);
         checkOutput($sformatf("vec%0d cmd_vld count", k), cmd_seen, 1);
         checkOutput($sformatf("vec%0d erro_flag", k), erro_flag, vecs[k].err);
         np = prog_log.size() - prog_start;
         checkOutput($sformatf("vec%0d prog count", k), np, vecs[k].nprog);
         if (np >= 1 && vecs[k].nprog >= 1)
            checkOutput($sformatf("vec%0d prog[0]", k), prog_log[prog_start], vecs[k].p0);
         if (np >= 2 && vecs[k].nprog >= 2)
            checkOutput($sformatf("vec%0d prog[1]", k), prog_log[prog_start+1], vecs[k].p1);
      end

      // Deselect in the middle of a READ address byte, then a clean RDID
      spi_cs = 1'b0;
      repeat (4) @(negedge sys_clk);
      xfer_bits(8'h03, 8, r);
      xfer_bits(8'hFF, 5, r);
      spi_cs = 1'b1;
      repeat (6) @(negedge sys_clk);
      checkOutput("abort miso", spi_miso, 0);
      q = {8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(q);
      checkOutput("abort rdid byte0", act_rx[1], 8'hEF);
      checkOutput("abort rdid byte1", act_rx[2], 8'h40);
      checkOutput("abort rdid byte2", act_rx[3], 8'h17);
      checkOutput("abort rdid byte3", act_rx[4], 8'h00);
      checkOutput("abort rdid cmd_code", cmd_code, 8'h9F);

      // Asynchronous reset in the middle of a READ data byte
      spi_cs = 1'b0;
      repeat (4) @(negedge sys_clk);
      xfer_bits(8'h03, 8, r);
      xfer_bits(8'h00, 8, r);
      xfer_bits(8'h00, 8, r);
      xfer_bits(8'h10, 8, r);
      xfer_bits(8'h00, 3, r);
      sys_rst = 1'b1;
      #1;
      check_reset_values("midread");
      repeat (2) @(negedge sys_clk);
      spi_cs  = 1'b1;
      spi_clk = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      repeat (4) @(negedge sys_clk);
      q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
      applyStimulus(q);
      checkOutput("post-reset array", act_rx[4], 8'hFF);
      checkOutput("post-reset erro_flag", erro_flag, 0);

      // Random transactions against the model, addresses clustered so reads hit writes
      for (int t = 0; t < 30; t++) begin
         sel = $urandom_range(0, 19);
         hi  = 16'($urandom);
         lo  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8, 15)) : 8'($urandom_range(252, 255));
         q   = {};
         if (sel < 4) begin
            q.push_back(8'h06);
         end else if (sel < 9) begin
            q.push_back(8'h02);
            q.push_back(hi[15:8]);
            q.push_back(hi[7:0]);
            q.push_back(lo);
            repeat ($urandom_range(0, 3)) q.push_back(8'($urandom));
         end else if (sel < 14) begin
            q.push_back(8'h03);
            q.push_back(hi[15:8]);
            q.push_back(hi[7:0]);
            q.push_back(lo);
            repeat ($urandom_range(1, 4)) q.push_back(8'($urandom));
         end else if (sel < 16) begin
            q.push_back(8'h05);
            repeat ($urandom_range(1, 2)) q.push_back(8'($urandom));
         end else if (sel < 17) begin
            q.push_back(8'h9F);
            repeat (4) q.push_back(8'($urandom));
         end else if (sel < 19) begin
            q.push_back(8'h04);
         end else begin
            q.push_back(8'hAB + 8'($urandom_range(0, 1)));
            q.push_back(8'h00);
         end
         applyStimulus(q);
         compare_model($sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
